// File: rtl/spawn_param_gen.sv
// spawn_param_gen: per-frame pseudo-random spawn X/speed/direction with a frame-driven difficulty level
module spawn_param_gen #(
  parameter logic [15:0] SEED = 16'hACE1,
  parameter int X_MIN = 30,
  parameter int X_SPAN = 571,
  parameter int LEVEL_FRAMES = 600,
  parameter int MAX_LEVEL = 7
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       freeze,
  input  logic       level_clr,
  output logic [9:0] set_position_x,
  output logic [4:0] x_speed,
  output logic [4:0] y_speed,
  output logic       sign,
  output logic [2:0] level,
  output logic       spawn_valid
);
  localparam int CW = (LEVEL_FRAMES > 1) ? $clog2(LEVEL_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LEVEL_FRAMES - 1);
  localparam logic [9:0] XMIN = 10'(X_MIN);
  localparam logic [9:0] XSPAN = 10'(X_SPAN);
  localparam logic [2:0] LMAX = 3'(MAX_LEVEL);
  logic [15:0] lfsr, lfsr_nxt, snap;
  logic [CW-1:0] frame_cnt;
  logic [2:0] lvl0, lvl1, ys_raw;
  logic [9:0] red;
  logic [1:0] xs;
  logic sg, v0, v1;
  assign lfsr_nxt = (lfsr == 16'h0) ? SEED : ({1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0));
  // free-running Galois LFSR, self-recovers from the all-zero lockup state
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) lfsr <= SEED;
    else lfsr <= lfsr_nxt;
  end
  // frame counter and saturating difficulty level; clear wins over a concurrent tick
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      frame_cnt <= '0;
      level <= 3'd0;
    end else if (level_clr) begin
      frame_cnt <= '0;
      level <= 3'd0;
    end else if (frame_tick && !freeze) begin
      frame_cnt <= (frame_cnt == CNT_LAST) ? '0 : frame_cnt + 1'b1;
      level <= (frame_cnt == CNT_LAST && level < LMAX) ? level + 3'd1 : level;
    end
  end
  // snapshot on tick, then range-reduce the X field with a single conditional subtract
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      v0 <= 1'b0;
      v1 <= 1'b0;
      snap <= 16'h0;
      lvl0 <= 3'd0;
      red <= 10'd0;
      ys_raw <= 3'd0;
      xs <= 2'd0;
      sg <= 1'b0;
      lvl1 <= 3'd0;
    end else begin
      v0 <= frame_tick;
      v1 <= v0;
      if (frame_tick) begin
        snap <= lfsr;
        lvl0 <= level;
      end
      if (v0) begin
        red <= (snap[9:0] >= XSPAN) ? snap[9:0] - XSPAN : snap[9:0];
        ys_raw <= snap[12:10];
        xs <= snap[15:14];
        sg <= snap[13];
        lvl1 <= lvl0;
      end
    end
  end
  // output registers hold between updates; spawn_valid pulses for one cycle per update
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      set_position_x <= 10'd300;
      x_speed <= 5'd0;
      y_speed <= 5'd0;
      sign <= 1'b0;
      spawn_valid <= 1'b0;
    end else begin
      spawn_valid <= v1;
      if (v1) begin
        set_position_x <= red + XMIN;
        x_speed <= {3'b0, xs};
        sign <= sg;
        y_speed <= {2'b0, (ys_raw < lvl1) ? ys_raw : lvl1};
      end
    end
  end
endmodule

// File: tb/tb_spawn_param_gen.sv
// tb_spawn_param_gen: scoreboard bench for spawn_param_gen
module tb_spawn_param_gen;
  typedef struct packed {
    logic [9:0] x;
    logic [4:0] xs;
    logic [4:0] ys;
    logic sg;
    logic [31:0] t;
  } spawn_t;
  logic Clk = 0, Reset = 0, frame_tick = 0, freeze = 0, level_clr = 0, tick2 = 0;
  logic [9:0] set_position_x, x2;
  logic [4:0] x_speed, y_speed, xs2, y2;
  logic sign, sg2, spawn_valid, sv2;
  logic [2:0] level, lv2;
  int n = 0, err = 0, ro = 0, re = 0, hold_bad = 0;
  logic [31:0] edges = 0;
  logic [15:0] m_lfsr;
  int m_cnt;
  logic [2:0] m_lvl;
  logic mv0, mv1;
  spawn_t mp0, mp1;
  spawn_t exp_q[$], obs_q[$];
  logic [20:0] last;

  spawn_param_gen dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .freeze(freeze), .level_clr(level_clr),
    .set_position_x(set_position_x), .x_speed(x_speed), .y_speed(y_speed), .sign(sign),
    .level(level), .spawn_valid(spawn_valid)
  );
  spawn_param_gen #(.LEVEL_FRAMES(4)) dut2 (
    .Clk(Clk), .Reset(Reset), .frame_tick(tick2), .freeze(freeze), .level_clr(level_clr),
    .set_position_x(x2), .x_speed(xs2), .y_speed(y2), .sign(sg2),
    .level(lv2), .spawn_valid(sv2)
  );

  always #10 Clk = ~Clk;

  function automatic logic [15:0] step(logic [15:0] v);
    return (v == 16'h0) ? 16'hACE1 : ({1'b0, v[15:1]} ^ ({16{v[0]}} & 16'hB400));
  endfunction

  function automatic spawn_t predict(logic [15:0] s, logic [2:0] l);
    spawn_t p;
    int r;
    r = int'(s[9:0]);
    if (r >= 571) r -= 571;
    p.x = 10'(r + 30);
    p.xs = {3'b0, s[15:14]};
    p.ys = {2'b0, (s[12:10] > l) ? l : s[12:10]};
    p.sg = s[13];
    p.t = 0;
    return p;
  endfunction

  // reference model of the main instance: expectation enters exp_q on the edge it is due
  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      m_lfsr = 16'hACE1;
      m_cnt = 0;
      m_lvl = 3'd0;
      mv0 = 1'b0;
      mv1 = 1'b0;
    end else begin
      edges = edges + 1;
      if (mv1) begin
        mp1.t = edges;
        exp_q.push_back(mp1);
      end
      mv1 = mv0;
      mp1 = mp0;
      mv0 = frame_tick;
      mp0 = predict(m_lfsr, m_lvl);
      m_lfsr = step(m_lfsr);
      if (level_clr) begin
        m_cnt = 0;
        m_lvl = 3'd0;
      end else if (frame_tick && !freeze) begin
        m_cnt++;
        if (m_cnt == 600) begin
          m_cnt = 0;
          if (m_lvl < 3'd7) m_lvl++;
        end
      end
    end
  end

  // record every update of the main instance and count output changes without spawn_valid
  always @(negedge Clk) begin
    if (Reset && spawn_valid === 1'b1) obs_q.push_back('{set_position_x, x_speed, y_speed, sign, edges});
    if (Reset && spawn_valid !== 1'b1 && {set_position_x, x_speed, y_speed, sign} !== last) hold_bad++;
    last = {set_position_x, x_speed, y_speed, sign};
  end

  task automatic test_reset;
    Reset = 0;
    repeat (3) @(negedge Clk);
    #1 Reset = 1;
    repeat (2) @(negedge Clk);
    frame_tick = 1;
    @(negedge Clk) frame_tick = 0;
    repeat (3) @(negedge Clk);
    frame_tick = 1;
    @(negedge Clk) frame_tick = 0;
    @(posedge Clk);
    #2 Reset = 0;
    #1;
    n++;
    if (set_position_x !== 10'd300 || x_speed !== 5'd0 || y_speed !== 5'd0 || sign !== 1'b0 || spawn_valid !== 1'b0 || level !== 3'd0) begin
      err++;
      $display("FAIL reset_outputs got x=%0d xs=%0d ys=%0d sg=%0d sv=%0d lv=%0d want 300/0/0/0/0/0", set_position_x, x_speed, y_speed, sign, spawn_valid, level);
    end
    repeat (2) @(negedge Clk);
    #1 Reset = 1;
    n++;
    if (dut.lfsr !== 16'hACE1) begin
      err++;
      $display("FAIL reset_lfsr got %h want ace1", dut.lfsr);
    end
  endtask

  task automatic test_first_spawn;
    @(posedge Clk);
    #1;
    n++;
    if (dut.lfsr !== 16'hE270) begin
      err++;
      $display("FAIL first_step got %h want e270", dut.lfsr);
    end
    @(negedge Clk) frame_tick = 1;
    @(negedge Clk) frame_tick = 0;
    @(negedge Clk);
    n++;
    if (spawn_valid !== 1'b0) begin
      err++;
      $display("FAIL first_early got sv=%0d want 0", spawn_valid);
    end
    @(negedge Clk);
    n++;
    if (set_position_x !== 10'd83 || x_speed !== 5'd3 || sign !== 1'b1 || y_speed !== 5'd0 || spawn_valid !== 1'b1) begin
      err++;
      $display("FAIL first_spawn got x=%0d xs=%0d sg=%0d ys=%0d sv=%0d want 83/3/1/0/1", set_position_x, x_speed, sign, y_speed, spawn_valid);
    end
    @(negedge Clk);
    n++;
    if (spawn_valid !== 1'b0) begin
      err++;
      $display("FAIL first_pulse got sv=%0d want 0", spawn_valid);
    end
    n++;
    if (obs_q.size() - ro != exp_q.size() - re) begin
      err++;
      $display("FAIL first_count got %0d want %0d", obs_q.size() - ro, exp_q.size() - re);
    end
    while (ro < obs_q.size() && re < exp_q.size()) begin
      n++;
      if (obs_q[ro] !== exp_q[re]) begin
        err++;
        $display("FAIL first_sb got x=%0d xs=%0d ys=%0d sg=%0d t=%0d want x=%0d xs=%0d ys=%0d sg=%0d t=%0d", obs_q[ro].x, obs_q[ro].xs, obs_q[ro].ys, obs_q[ro].sg, obs_q[ro].t, exp_q[re].x, exp_q[re].xs, exp_q[re].ys, exp_q[re].sg, exp_q[re].t);
      end
      ro++;
      re++;
    end
    ro = obs_q.size();
    re = exp_q.size();
  endtask

  task automatic test_range;
    logic [9:0] raws [4] = '{10'd0, 10'd570, 10'd571, 10'd1023};
    logic [9:0] xw [4] = '{10'd30, 10'd600, 10'd30, 10'd482};
    for (int i = 0; i < 4; i++) begin
      bit found = 0;
      for (int c = 0; c < 8000 && !found; c++) begin
        @(negedge Clk);
        found = (m_lfsr[9:0] == raws[i]);
      end
      n++;
      if (!found) begin
        err++;
        $display("FAIL range_search raw=%0d got timeout want hit", raws[i]);
      end else begin
        frame_tick = 1;
        @(negedge Clk) frame_tick = 0;
        repeat (2) @(negedge Clk);
        n++;
        if (set_position_x !== xw[i] || spawn_valid !== 1'b1) begin
          err++;
          $display("FAIL range_x raw=%0d got %0d sv=%0d want %0d", raws[i], set_position_x, spawn_valid, xw[i]);
        end
      end
    end
    @(negedge Clk);
    n++;
    if (obs_q.size() - ro != exp_q.size() - re) begin
      err++;
      $display("FAIL range_count got %0d want %0d", obs_q.size() - ro, exp_q.size() - re);
    end
    while (ro < obs_q.size() && re < exp_q.size()) begin
      n++;
      if (obs_q[ro] !== exp_q[re]) begin
        err++;
        $display("FAIL range_sb got x=%0d ys=%0d t=%0d want x=%0d ys=%0d t=%0d", obs_q[ro].x, obs_q[ro].ys, obs_q[ro].t, exp_q[re].x, exp_q[re].ys, exp_q[re].t);
      end
      ro++;
      re++;
    end
    ro = obs_q.size();
    re = exp_q.size();
  endtask

  task automatic test_random;
    for (int i = 0; i < 10000; i++) begin
      frame_tick = 1;
      freeze = ($urandom_range(0, 7) == 0);
      level_clr = ($urandom_range(0, 2999) == 0);
      @(negedge Clk);
      frame_tick = 0;
      freeze = 0;
      level_clr = 0;
      repeat ($urandom_range(0, 1)) @(negedge Clk);
    end
    repeat (3) @(negedge Clk);
    n++;
    if (level !== m_lvl) begin
      err++;
      $display("FAIL random_level got %0d want %0d", level, m_lvl);
    end
    n++;
    if (obs_q.size() - ro != exp_q.size() - re) begin
      err++;
      $display("FAIL random_count got %0d want %0d", obs_q.size() - ro, exp_q.size() - re);
    end
    while (ro < obs_q.size() && re < exp_q.size()) begin
      n++;
      if (obs_q[ro] !== exp_q[re] || obs_q[ro].x < 10'd30 || obs_q[ro].x > 10'd600) begin
        err++;
        $display("FAIL random_sb got x=%0d xs=%0d ys=%0d sg=%0d t=%0d want x=%0d xs=%0d ys=%0d sg=%0d t=%0d", obs_q[ro].x, obs_q[ro].xs, obs_q[ro].ys, obs_q[ro].sg, obs_q[ro].t, exp_q[re].x, exp_q[re].xs, exp_q[re].ys, exp_q[re].sg, exp_q[re].t);
      end
      ro++;
      re++;
    end
    ro = obs_q.size();
    re = exp_q.size();
  endtask

  task automatic test_back_to_back;
    @(negedge Clk) frame_tick = 1;
    repeat (3) @(negedge Clk);
    frame_tick = 0;
    repeat (4) @(negedge Clk);
    n++;
    if (obs_q.size() - ro != 3 || exp_q.size() - re != 3) begin
      err++;
      $display("FAIL b2b_count got %0d want 3", obs_q.size() - ro);
    end else begin
      n++;
      if (obs_q[ro + 1].t != obs_q[ro].t + 1 || obs_q[ro + 2].t != obs_q[ro].t + 2) begin
        err++;
        $display("FAIL b2b_spacing got t=%0d,%0d,%0d want consecutive", obs_q[ro].t, obs_q[ro + 1].t, obs_q[ro + 2].t);
      end
    end
    while (ro < obs_q.size() && re < exp_q.size()) begin
      n++;
      if (obs_q[ro] !== exp_q[re]) begin
        err++;
        $display("FAIL b2b_sb got x=%0d xs=%0d ys=%0d sg=%0d t=%0d want x=%0d xs=%0d ys=%0d sg=%0d t=%0d", obs_q[ro].x, obs_q[ro].xs, obs_q[ro].ys, obs_q[ro].sg, obs_q[ro].t, exp_q[re].x, exp_q[re].xs, exp_q[re].ys, exp_q[re].sg, exp_q[re].t);
      end
      ro++;
      re++;
    end
    ro = obs_q.size();
    re = exp_q.size();
  endtask

  task automatic test_difficulty;
    int k = 0;
    bit found = 0;
    logic [2:0] lw;
    Reset = 0;
    repeat (2) @(negedge Clk);
    #1 Reset = 1;
    while (k < 8) begin
      @(negedge Clk) tick2 = 1;
      @(negedge Clk) tick2 = 0;
      k++;
      lw = 3'(k / 4);
      n++;
      if (lv2 !== lw) begin
        err++;
        $display("FAIL diff_level tick=%0d got %0d want %0d", k, lv2, lw);
      end
    end
    for (int c = 0; c < 8000 && !found; c++) begin
      @(negedge Clk);
      found = (m_lfsr[12:10] == 3'd5);
    end
    tick2 = 1;
    @(negedge Clk) tick2 = 0;
    k++;
    repeat (2) @(negedge Clk);
    n++;
    if (!found || y2 !== 5'd2 || sv2 !== 1'b1 || lv2 !== 3'd2) begin
      err++;
      $display("FAIL diff_yspeed got ys=%0d sv=%0d lv=%0d found=%0d want 2/1/2/1", y2, sv2, lv2, found);
    end
    freeze = 1;
    repeat (8) begin
      @(negedge Clk) tick2 = 1;
      @(negedge Clk) tick2 = 0;
      n++;
      if (lv2 !== 3'd2) begin
        err++;
        $display("FAIL diff_freeze got %0d want 2", lv2);
      end
    end
    freeze = 0;
    while (k < 40) begin
      @(negedge Clk) tick2 = 1;
      @(negedge Clk) tick2 = 0;
      k++;
      lw = (k / 4 > 7) ? 3'd7 : 3'(k / 4);
      n++;
      if (lv2 !== lw) begin
        err++;
        $display("FAIL diff_level tick=%0d got %0d want %0d", k, lv2, lw);
      end
    end
  endtask

  task automatic test_level_clr;
    bit found = 0;
    Reset = 0;
    repeat (2) @(negedge Clk);
    #1 Reset = 1;
    repeat (21) begin
      @(negedge Clk) tick2 = 1;
      @(negedge Clk) tick2 = 0;
    end
    n++;
    if (lv2 !== 3'd5) begin
      err++;
      $display("FAIL clr_setup got %0d want 5", lv2);
    end
    for (int c = 0; c < 8000 && !found; c++) begin
      @(negedge Clk);
      found = (m_lfsr[12:10] == 3'd7);
    end
    tick2 = 1;
    level_clr = 1;
    @(negedge Clk);
    tick2 = 0;
    level_clr = 0;
    n++;
    if (lv2 !== 3'd0 || dut2.frame_cnt !== '0) begin
      err++;
      $display("FAIL clr_level got lv=%0d cnt=%0d want 0/0", lv2, dut2.frame_cnt);
    end
    repeat (2) @(negedge Clk);
    n++;
    if (!found || y2 !== 5'd5 || sv2 !== 1'b1) begin
      err++;
      $display("FAIL clr_snapshot got ys=%0d sv=%0d found=%0d want 5/1/1", y2, sv2, found);
    end
  endtask

  task automatic test_lockup;
    @(negedge Clk);
    force dut.lfsr = 16'h0;
    #1 release dut.lfsr;
    @(negedge Clk);
    n++;
    if (dut.lfsr !== 16'hACE1) begin
      err++;
      $display("FAIL lockup got %h want ace1", dut.lfsr);
    end
  endtask

  task automatic test_hold;
    n++;
    if (hold_bad !== 0) begin
      err++;
      $display("FAIL hold got %0d changes want 0", hold_bad);
    end
  endtask

  initial begin
    test_reset;
    test_first_spawn;
    test_range;
    test_random;
    test_back_to_back;
    test_difficulty;
    test_level_clr;
    test_lockup;
    test_hold;
    $display("== %0d vectors applied, %0d miscompares ==", n, err);
    $finish;
  end
endmodule

// File: doc/spawn_param_gen.md
# spawn_param_gen

Pseudo-random spawn parameter generator that sits directly upstream of the obstacle/asteroid block. It supplies the respawn X position, lateral speed, lateral direction bit and extra fall speed that the obstacle block consumes when it reactivates or recycles an asteroid. A free-running 16-bit LFSR is snapshotted once per frame, range-reduced through a 2-stage pipeline, and held stable for the whole frame. A frame-driven difficulty level caps the extra fall speed.

## Interface
Parameters:
- SEED, 16'hACE1, LFSR reset value; must be nonzero.
- X_MIN, 30, lowest spawn X.
- X_SPAN, 571, number of legal spawn X values (X_MIN..X_MIN+X_SPAN-1 = 30..600); must satisfy X_SPAN ≤ 1023 < 2·X_SPAN.
- LEVEL_FRAMES, 600, frames per difficulty level step.
- MAX_LEVEL, 7, level saturation value (≤ 7).

Ports:
- Clk  in  1  system clock (50 MHz).
- Reset  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-Clk pulse per video frame.
- freeze  in  1  when high, frame counter and level hold; LFSR keeps running.
- level_clr  in  1  synchronous clear of level and frame counter.
- set_position_x  out  10  spawn X, always in [X_MIN, X_MIN+X_SPAN-1].
- x_speed  out  5  lateral speed magnitude, 0..3.
- y_speed  out  5  extra fall speed, 0..level.
- sign  out  1  lateral direction request.
- level  out  3  current difficulty level.
- spawn_valid  out  1  one-cycle pulse when outputs update.

## Operation
- LFSR: 16-bit Galois, shift right every Clk; if the old bit0 is 1, XOR the result with 16'hB400. If the register is ever 0, load SEED on the next edge.
- Stage 0 (edge where frame_tick=1): snap ← current LFSR value (pre-step); lvl_snap ← level (pre-increment).
- Stage 1: raw = snap[9:0]; red = (raw ≥ X_SPAN) ? raw − X_SPAN : raw (single conditional subtract). Also register ys_raw = snap[12:10], xs = snap[15:14], sg = snap[13], and lvl_snap.
- Stage 2 (output registers):
  - set_position_x ← red + X_MIN
  - x_speed ← {3'b0, xs}
  - sign ← sg
  - y_speed ← {2'b0, min(ys_raw, lvl_snap)}
  - spawn_valid ← 1
- Between updates, all outputs except spawn_valid hold their values.
- Level logic: on a frame_tick with freeze=0, the frame counter increments. On reaching LEVEL_FRAMES−1 it wraps to 0 and level increments, saturating at MAX_LEVEL.
- level_clr has priority over frame_tick: counter and level go to 0, and a concurrent tick is not counted. The pipeline still snapshots on that tick using the pre-clear level.
- Pipeline is fully pipelined: back-to-back frame_ticks are accepted every cycle, and each produces its own update 2 edges later.

## Timing
- Reset (asynchronous assert) sets:
  - LFSR=SEED, frame counter=0, level=0
  - set_position_x=300, x_speed=0, y_speed=0, sign=0, spawn_valid=0
  - all pipeline valid bits cleared
- Reset mid-pipeline discards in-flight snapshots; no spawn_valid is produced for them.
- Latency: frame_tick sampled at edge E → outputs and spawn_valid=1 visible after edge E+2; spawn_valid low after E+3 unless another tick arrived.
- Outputs are stable for at least one full frame, so the obstacle block may sample them on any later frame_clk.
- Level changes after the tick edge; the first snapshot that sees the new level is the next tick.
- Arithmetic: all X math is 10-bit unsigned. X_MIN+X_SPAN−1 ≤ 1023, so there is no overflow. The min() compare is 3-bit unsigned.

## Test plan
- Reset values: assert Reset=0 mid-operation → all outputs at the reset values above within the same cycle; LFSR reads 16'hACE1 after release.
- First spawn: release reset; the first edge steps LFSR to 16'hE270; pulse frame_tick on the second edge → 2 edges later set_position_x=83 (624−571+30), x_speed=3, sign=1, y_speed=0, spawn_valid high for exactly 1 cycle.
- Range sweep: force snap raw values 0, 570, 571, 1023 → set_position_x = 30, 600, 30, 482; run 10 000 random frames and confirm set_position_x always stays in 30..600.
- Difficulty: LEVEL_FRAMES=4, 40 ticks → level steps every 4 ticks and holds at 7. With level=2 and ys_raw=5 → y_speed=2. With freeze=1 for 8 ticks → level unchanged.
- level_clr with frame_tick in the same cycle at level=5 → level=0 and frame counter=0 next cycle; that tick's output uses lvl_snap=5.
- Lockup: force LFSR=0 → LFSR=16'hACE1 next edge. Back-to-back ticks on 3 consecutive cycles → 3 consecutive spawn_valid pulses with distinct snapshots.
